// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one read at a time to instruction memory,
// buffers returned words with their addresses and hands them to decode.
// Optional macro IFQ_BYPASS_EN: forwards an ack word straight to decode
// in the ack cycle when the queue is empty.
module ifetch_queue #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDR_W-1:0]        pc_addr_i,
    output logic                     pc_hold_o,
    input  logic                     flush_i,
    output logic                     imem_req_o,
    output logic [ADDR_W-1:0]        imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [INSTR_W-1:0]       imem_rdata_i,
    output logic                     instr_valid_o,
    output logic [INSTR_W-1:0]       instr_o,
    output logic [ADDR_W-1:0]        instr_pc_o,
    input  logic                     instr_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_DROP     = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    logic                issue;
    logic                fifo_valid;
    logic                fifo_push;
    logic                fifo_pop;
    logic                byp_take;
    logic [ENTRY_W-1:0]  head;

    assign fifo_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];

`ifdef IFQ_BYPASS_EN
    logic byp_valid;
    // Empty queue and a live ack: present the memory word directly.
    assign byp_valid     = (state_q == S_WAIT_ACK) && imem_ack_i && !flush_i && !fifo_valid;
    assign byp_take      = byp_valid && instr_ready_i;
    assign instr_valid_o = fifo_valid || byp_valid;
    assign instr_o       = fifo_valid ? head[INSTR_W-1:0] : imem_rdata_i;
    assign instr_pc_o    = fifo_valid ? head[ENTRY_W-1:INSTR_W] : addr_q;
`else
    assign byp_take      = 1'b0;
    assign instr_valid_o = fifo_valid;
    assign instr_o       = head[INSTR_W-1:0];
    assign instr_pc_o    = head[ENTRY_W-1:INSTR_W];
`endif

    assign pc_hold_o    = !issue;
    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign fifo_count_o = count_q;

    // State register and registered memory request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state: one outstanding read; a flush while waiting turns it stale.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (issue) state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (imem_ack_i)   state_d = S_IDLE;
                else if (flush_i) state_d = S_DROP;
            end
            S_DROP:     if (imem_ack_i) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs: issue decision, request hold/release and queue control.
    always_comb begin
        issue     = 1'b0;
        req_d     = req_q;
        addr_d    = addr_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            S_IDLE: begin
                issue = (count_q < FULL_CNT) && !flush_i;
                if (issue) begin
                    req_d  = 1'b1;
                    addr_d = pc_addr_i;
                end
            end
            S_WAIT_ACK: begin
                if (imem_ack_i) begin
                    req_d     = 1'b0;
                    fifo_push = !flush_i && !byp_take;
                end
            end
            S_DROP: begin
                if (imem_ack_i) req_d = 1'b0;
            end
            default: req_d = 1'b0;
        endcase
        fifo_pop = fifo_valid && instr_ready_i && !flush_i;
    end

    // Occupancy: flush empties the queue; push+pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({fifo_push, fifo_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Queue storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk_i) begin
        if (fifo_push) mem_q[wr_ptr_q] <= {addr_q, imem_rdata_i};
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: random decode/flush/memory timing
// against a queue-based reference model.
module tb_ifetch_queue;

    localparam int unsigned AW    = 16;
    localparam int unsigned IW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] pc_addr_i;
    logic          pc_hold_o;
    logic          flush_i;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_ack_i;
    logic [IW-1:0] imem_rdata_i;
    logic          instr_valid_o;
    logic [IW-1:0] instr_o;
    logic [AW-1:0] instr_pc_o;
    logic          instr_ready_i;
    logic [CW-1:0] fifo_count_o;

    ifetch_queue #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_addr_i    (pc_addr_i),
        .pc_hold_o    (pc_hold_o),
        .flush_i      (flush_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_ready_i(instr_ready_i),
        .fifo_count_o (fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding read, stale flag, queue of {pc,data}.
    bit            m_req;
    bit            m_stale;
    logic [AW-1:0] m_addr;
    int            m_wait;
    logic [AW-1:0] qa[$];
    logic [IW-1:0] qd[$];
    logic [AW-1:0] pc;
    logic [AW-1:0] delivered[$];

    // Stimulus knobs.
    int            k_ready, k_flush, k_dmin, k_dmax, k_spur;
    bit            force_flush;
    logic [AW-1:0] force_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 16'hBEFF;
    endfunction

    task automatic model_reset(input logic [AW-1:0] start_pc);
        m_req   = 1'b0;
        m_stale = 1'b0;
        m_addr  = '0;
        m_wait  = 0;
        qa.delete();
        qd.delete();
        delivered.delete();
        pc = start_pc;
    endtask

    task automatic drive();
        bit ack;
        rst_i         = 1'b0;
        instr_ready_i = ($urandom_range(99) < k_ready);
        flush_i       = force_flush || ($urandom_range(99) < k_flush);
        pc_addr_i     = pc;
        ack           = m_req ? (m_wait == 0) : ($urandom_range(99) < k_spur);
        imem_ack_i    = ack;
        imem_rdata_i  = m_req ? mem_word(m_addr) : IW'($urandom);
    endtask

    task automatic check_and_step();
        bit            issue_e, byp_e, valid_e, ack;
        logic [AW-1:0] exp_pc;
        logic [IW-1:0] exp_d;
        ack     = imem_ack_i;
        issue_e = !m_req && (qa.size() < DEPTH) && !flush_i;
        byp_e   = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp_e   = m_req && !m_stale && ack && !flush_i && (qa.size() == 0);
`endif
        valid_e = (qa.size() > 0) || byp_e;
        exp_pc  = (qa.size() > 0) ? qa[0] : m_addr;
        exp_d   = (qa.size() > 0) ? qd[0] : imem_rdata_i;

        check_eq("pc_hold", 32'(pc_hold_o), 32'(!issue_e));
        check_eq("imem_req", 32'(imem_req_o), 32'(m_req));
        check_eq("imem_addr", 32'(imem_addr_o), 32'(m_addr));
        check_eq("instr_valid", 32'(instr_valid_o), 32'(valid_e));
        check_eq("fifo_count", 32'(fifo_count_o), qa.size());
        if (valid_e) begin
            check_eq("instr", 32'(instr_o), 32'(exp_d));
            check_eq("instr_pc", 32'(instr_pc_o), 32'(exp_pc));
            if (instr_ready_i) delivered.push_back(exp_pc);
        end

        if (flush_i) begin
            qa.delete();
            qd.delete();
            if (m_req && !ack) m_stale = 1'b1;
        end else begin
            if (valid_e && instr_ready_i && qa.size() > 0) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (m_req && ack && !m_stale && !(byp_e && instr_ready_i)) begin
                qa.push_back(m_addr);
                qd.push_back(mem_word(m_addr));
            end
        end
        if (m_req) begin
            if (ack) begin
                m_req   = 1'b0;
                m_stale = 1'b0;
            end else begin
                m_wait--;
            end
        end
        if (issue_e) begin
            m_req   = 1'b1;
            m_stale = 1'b0;
            m_addr  = pc;
            m_wait  = $urandom_range(k_dmax, k_dmin);
        end
        if (flush_i) pc = force_flush ? force_pc : AW'($urandom);
        else if (issue_e) pc = pc + AW'(1);
        force_flush = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
            drive();
            #4;
            check_and_step();
        end
    endtask

    // Asynchronous reset mid-cycle; released at the next drive step.
    task automatic do_reset(input logic [AW-1:0] start_pc);
        #1;
        rst_i = 1'b1;
        #1;
        check_eq("rst_req", 32'(imem_req_o), 32'd0);
        check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
        check_eq("rst_count", 32'(fifo_count_o), 32'd0);
        flush_i    = 1'b0;
        imem_ack_i = 1'b0;
        model_reset(start_pc);
    endtask

    initial begin
        bit found;
        force_flush   = 1'b0;
        force_pc      = '0;
        rst_i         = 1'b0;
        flush_i       = 1'b0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        pc_addr_i     = '0;
        #1;
        rst_i = 1'b1;
        #3;
        check_eq("reset_req", 32'(imem_req_o), 32'd0);
        check_eq("reset_addr", 32'(imem_addr_o), 32'd0);
        check_eq("reset_valid", 32'(instr_valid_o), 32'd0);
        check_eq("reset_count", 32'(fifo_count_o), 32'd0);
        model_reset(16'h0000);

        // In-order delivery from PC 0 with decode always ready.
        k_ready = 100; k_flush = 0; k_dmin = 0; k_dmax = 0; k_spur = 0;
        run(12);
        check_eq("seq_len_ok", 32'(delivered.size() >= 3), 32'd1);
        if (delivered.size() >= 3) begin
            check_eq("seq0", 32'(delivered[0]), 32'h0000);
            check_eq("seq1", 32'(delivered[1]), 32'h0001);
            check_eq("seq2", 32'(delivered[2]), 32'h0002);
        end

        // Decode stalled: queue fills and the PC holds.
        k_ready = 0;
        run(20);
        check_eq("full_count", 32'(fifo_count_o), DEPTH);
        check_eq("full_hold", 32'(pc_hold_o), 32'd1);
        k_ready = 100;
        run(1);
        k_ready = 0;
        run(6);

        // Flush while waiting at 0x0005, redirect to 0x0040.
        do_reset(16'h0005);
        k_ready = 100; k_dmin = 3; k_dmax = 3;
        run(2);
        force_flush = 1'b1;
        force_pc    = 16'h0040;
        run(12);
        found = 1'b0;
        foreach (delivered[i]) if (delivered[i] == 16'h0005) found = 1'b1;
        check_eq("stale_dropped", 32'(found), 32'd0);
        check_eq("redirect_first", 32'(delivered.size() > 0 ? delivered[0] : 16'hFFFF), 32'h0040);

        // Flush coinciding with ack.
        do_reset(16'h0020);
        k_dmin = 1; k_dmax = 1;
        run(2);
        force_flush = 1'b1;
        force_pc    = 16'h0030;
        run(6);

        // Async reset while waiting with two entries queued.
        do_reset(16'h0100);
        k_ready = 0; k_dmin = 3; k_dmax = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            run(1);
            found = m_req && (qa.size() == 2);
        end
        check_eq("async_setup", 32'(found), 32'd1);
        do_reset(16'h0123);
        k_ready = 100;
        run(6);

        // Empty-queue ack carrying 0xBEEF at 0x0010.
        do_reset(16'h0010);
        k_ready = 100; k_dmin = 1; k_dmax = 1;
        run(2);
        @(posedge clk_i);
        #1;
        drive();
        #4;
`ifdef IFQ_BYPASS_EN
        check_eq("byp_valid", 32'(instr_valid_o), 32'd1);
        check_eq("byp_instr", 32'(instr_o), 32'hBEEF);
`else
        check_eq("byp_valid", 32'(instr_valid_o), 32'd0);
`endif
        check_eq("byp_count", 32'(fifo_count_o), 32'd0);
        check_and_step();
        run(4);

        // Random traffic.
        k_ready = 70; k_flush = 8; k_dmin = 0; k_dmax = 3; k_spur = 10;
        run(3000);
        k_ready = 30; k_flush = 3;
        run(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Samples the current instruction address, issues one read at a time to instruction memory over a req/ack handshake, and buffers returned words in a small FIFO.
- Delivers each word with its address to decode over valid/ready.
- Holds the PC while it cannot issue; discards stale data on a redirect (jump or taken branch).

Parameters:
- ADDR_W, 16, instruction address width (matches PC width).
- INSTR_W, 16, instruction word width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- pc_addr_i  input  ADDR_W  current PC value (instruction pointer).
- pc_hold_o  output  1  high = PC must not advance this cycle (address not consumed).
- flush_i  input  1  redirect: jump or taken branch resolved this cycle.
- imem_req_o  output  1  memory read request, registered.
- imem_addr_o  output  ADDR_W  memory read address, registered.
- imem_ack_i  input  1  read data valid, single-cycle pulse.
- imem_rdata_i  input  INSTR_W  read data, valid with imem_ack_i.
- instr_valid_o  output  1  instruction available to decode.
- instr_o  output  INSTR_W  instruction word (FIFO head).
- instr_pc_o  output  ADDR_W  address of instr_o.
- instr_ready_i  input  1  decode accepts instruction.
- fifo_count_o  output  log2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async):
  - State IDLE.
  - imem_req_o=0, imem_addr_o=0.
  - FIFO empty, count=0, instr_valid_o=0.
  - instr_o and instr_pc_o are don't-care while invalid.
- Issue condition (combinational): state==IDLE && count<DEPTH && !flush_i.
- pc_hold_o = !issue.
- On issue:
  - imem_addr_o <= pc_addr_i and imem_req_o <= 1 at the clock edge.
  - State goes to WAIT_ACK.
  - The PC advances on the same edge.
- Only one request is outstanding at a time. Space is reserved at issue, so a push can never overflow.
- WAIT_ACK:
  - imem_req_o and imem_addr_o held stable until imem_ack_i.
  - On ack without flush_i: push {imem_addr_o, imem_rdata_i}, imem_req_o <= 0, go to IDLE.
  - Memory latency is at least 1 cycle after the request becomes visible; an ack in IDLE is ignored.
- DROP:
  - Entered from WAIT_ACK when flush_i is high and ack is low.
  - imem_req_o stays high until ack; the ack data is discarded; then go to IDLE.
  - A further flush_i in DROP has no additional effect.
- Flush and ack in the same cycle in WAIT_ACK: data discarded, go to IDLE.
- flush_i in any state:
  - FIFO cleared at the edge (count=0, instr_valid_o=0 next cycle).
  - No issue that cycle. The new target is captured on the first IDLE cycle after the flush.
- Pop: instr_valid_o && instr_ready_i advances the head.
- Push and pop in the same cycle: count unchanged. Legal at any occupancy, including full.
- Pop and flush in the same cycle: flush wins; the popped entry is still considered consumed by decode.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count saturates by construction and never exceeds DEPTH.
- Non-bypass latency: address issued at edge N; ack in cycle N+k; instruction valid from edge N+k+1.
- Steady state: one instruction per 2+k cycles, where k is the ack delay in cycles after imem_req_o rises.

Optional Feature:
- IFQ_BYPASS_EN defined:
  - When the FIFO is empty and an ack arrives in WAIT_ACK without flush_i, instr_valid_o rises combinationally in the ack cycle, with instr_o=imem_rdata_i and instr_pc_o=imem_addr_o.
  - If instr_ready_i is high that cycle, the word is not pushed; otherwise it is pushed as normal.
- Not defined: instr_valid_o and instr_o are driven only from FIFO storage, with one cycle more latency.

Test Plan:
- Reset with pc_addr_i=0x0000 and ack 1 cycle after req, decode always ready -> imem_addr_o=0x0000 first; instructions 0x0000,0x0001,0x0002 delivered in order with matching instr_pc_o; pc_hold_o low exactly on issue cycles.
- Decode ready=0 with DEPTH=4 -> after 4 fetches fifo_count_o=4, pc_hold_o stuck at 1, imem_req_o=0; ready=1 for one cycle -> count=3, one new issue follows.
- flush_i in WAIT_ACK (addr 0x0005), pc_addr_i redirected to 0x0040, ack 3 cycles later -> the 0x0005 data is never delivered; the next issued address is 0x0040; FIFO empty after flush.
- flush_i and imem_ack_i in the same cycle -> data dropped, count=0, IDLE next cycle, next issue on the following cycle.
- rst_i asserted asynchronously mid-WAIT_ACK with FIFO count=2 -> imem_req_o=0, instr_valid_o=0, count=0 immediately without waiting for a clock; after release the first issue uses the current pc_addr_i.
- With IFQ_BYPASS_EN, FIFO empty, ready=1, ack carries 0xBEEF at 0x0010 -> instr_valid_o=1 and instr_o=0xBEEF in the ack cycle, count stays 0; without the macro, valid appears one cycle later.
